// File: rtl/sc_randreg_bank_pkg.sv
// rtl/sc_randreg_bank_pkg.sv - shared FSM states, LFSR tap table and clog2 helper
package sc_randreg_bank_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      LOAD     = 2'd1,
      CLEAR    = 2'd2,
      WAIT_REL = 2'd3
   } state_e;

   // Fibonacci feedback masks for maximal-length sequences, indexed by width
   localparam logic [15:0] LFSR_TAPS [4:16] = '{
      16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110, 16'h0240,
      16'h0500, 16'h0829, 16'h100D, 16'h2015, 16'h6000, 16'hD008
   };

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sc_randreg_lfsr.sv
// rtl/sc_randreg_lfsr.sv - free-running maximal-length Fibonacci LFSR with zero-state recovery
module sc_randreg_lfsr
   import sc_randreg_bank_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
   input  logic             clk,
   input  logic             rst,
   output logic [WIDTH-1:0] lfsr_o
);

   localparam logic [15:0]      TAP_ROW = LFSR_TAPS[WIDTH];
   localparam logic [WIDTH-1:0] TAPS    = TAP_ROW[WIDTH-1:0];

   logic [WIDTH-1:0] lfsr_q;
   logic [WIDTH-1:0] lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
      if (lfsr_q == '0) begin
         lfsr_d = SEED;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/sc_randreg_bank.sv
// rtl/sc_randreg_bank.sv - button-driven register bank loaded from a data bus or an LFSR
module sc_randreg_bank
   import sc_randreg_bank_pkg::*;
#(
   parameter int                       DATAWIDTH_BUS = 8,
   parameter int                       DEPTH         = 4,
   parameter int                       WRAP_MODE     = 0,
   parameter logic [DATAWIDTH_BUS-1:0] LFSR_SEED     = DATAWIDTH_BUS'(1)
) (
   input  logic                         SC_RANDREG_BANK_CLOCK_50,
   input  logic                         SC_RANDREG_BANK_RESET_InHigh,
   input  logic                         SC_RANDREG_BANK_clear_InLow,
   input  logic                         SC_RANDREG_BANK_load_InLow,
   input  logic                         SC_RANDREG_BANK_mode_In,
   input  logic [DATAWIDTH_BUS-1:0]     SC_RANDREG_BANK_data_InBUS,
   input  logic [clog2(DEPTH)-1:0]      SC_RANDREG_BANK_rdaddr_InBUS,
   output logic [DATAWIDTH_BUS-1:0]     SC_RANDREG_BANK_data_OutBUS,
   output logic [clog2(DEPTH):0]        SC_RANDREG_BANK_count_OutBUS,
   output logic                         SC_RANDREG_BANK_full_Out,
   output logic                         SC_RANDREG_BANK_overflow_Out,
   output logic                         SC_RANDREG_BANK_ack_Out
);

   localparam int AW = clog2(DEPTH);
   localparam int CW = AW + 1;

   logic                     clk;
   logic                     rst;
   logic [DATAWIDTH_BUS-1:0] lfsr_value;
   logic [DATAWIDTH_BUS-1:0] src;
   logic                     full;

   state_e                   state_q, state_d;
   logic [DATAWIDTH_BUS-1:0] regs_q [DEPTH];
   logic [DATAWIDTH_BUS-1:0] regs_d [DEPTH];
   logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]            count_q, count_d;
   logic                     overflow_q, overflow_d;
   logic                     ack_q, ack_d;
   logic [DATAWIDTH_BUS-1:0] data_out_q, data_out_d;

   assign clk = SC_RANDREG_BANK_CLOCK_50;
   assign rst = SC_RANDREG_BANK_RESET_InHigh;

   sc_randreg_lfsr #(
      .WIDTH (DATAWIDTH_BUS),
      .SEED  (LFSR_SEED)
   ) u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .lfsr_o (lfsr_value)
   );

   assign full = (count_q == CW'(DEPTH));
   assign src  = SC_RANDREG_BANK_mode_In ? lfsr_value : SC_RANDREG_BANK_data_InBUS;

   always_comb begin
      state_d    = state_q;
      regs_d     = regs_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      ack_d      = 1'b0;
      data_out_d = regs_q[SC_RANDREG_BANK_rdaddr_InBUS];

      case (state_q)
         IDLE: begin
            // clear wins over a simultaneous load
            if (!SC_RANDREG_BANK_clear_InLow) begin
               state_d = CLEAR;
            end else if (!SC_RANDREG_BANK_load_InLow) begin
               if (!full || (WRAP_MODE != 0)) begin
                  state_d = LOAD;
               end else begin
                  state_d    = WAIT_REL;
                  overflow_d = 1'b1;
               end
            end
         end
         LOAD: begin
            regs_d[wr_ptr_q] = src;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            if (!full) begin
               count_d = count_q + 1'b1;
            end
            ack_d   = 1'b1;
            state_d = WAIT_REL;
         end
         CLEAR: begin
            for (int i = 0; i < DEPTH; i++) begin
               regs_d[i] = '0;
            end
            wr_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            ack_d      = 1'b1;
            state_d    = WAIT_REL;
         end
         WAIT_REL: begin
            if (SC_RANDREG_BANK_clear_InLow && SC_RANDREG_BANK_load_InLow) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         ack_q      <= 1'b0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         regs_q     <= regs_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         ack_q      <= ack_d;
         data_out_q <= data_out_d;
      end
   end

   assign SC_RANDREG_BANK_data_OutBUS  = data_out_q;
   assign SC_RANDREG_BANK_count_OutBUS = count_q;
   assign SC_RANDREG_BANK_full_Out     = full;
   assign SC_RANDREG_BANK_overflow_Out = overflow_q;
   assign SC_RANDREG_BANK_ack_Out      = ack_q;

endmodule

// File: tb/tb_sc_randreg_bank.sv
// tb/tb_sc_randreg_bank.sv - directed table-driven bench for sc_randreg_bank (refuse and wrap variants)
module tb_sc_randreg_bank;
   import sc_randreg_bank_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear_n = 1'b1;
   logic       load_n = 1'b1;
   logic       mode = 1'b0;
   logic [7:0] data = 8'h00;
   logic [1:0] rdaddr = 2'd0;

   logic [7:0] dout, w_dout;
   logic [2:0] count, w_count;
   logic       full, w_full, ovf, w_ovf, ack, w_ack;

   logic [7:0] model_lfsr;

   int n_checks = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   sc_randreg_bank #(.DATAWIDTH_BUS(8), .DEPTH(4), .WRAP_MODE(0), .LFSR_SEED(8'h01)) dut (
      .SC_RANDREG_BANK_CLOCK_50     (clk),
      .SC_RANDREG_BANK_RESET_InHigh (rst),
      .SC_RANDREG_BANK_clear_InLow  (clear_n),
      .SC_RANDREG_BANK_load_InLow   (load_n),
      .SC_RANDREG_BANK_mode_In      (mode),
      .SC_RANDREG_BANK_data_InBUS   (data),
      .SC_RANDREG_BANK_rdaddr_InBUS (rdaddr),
      .SC_RANDREG_BANK_data_OutBUS  (dout),
      .SC_RANDREG_BANK_count_OutBUS (count),
      .SC_RANDREG_BANK_full_Out     (full),
      .SC_RANDREG_BANK_overflow_Out (ovf),
      .SC_RANDREG_BANK_ack_Out      (ack)
   );

   sc_randreg_bank #(.DATAWIDTH_BUS(8), .DEPTH(4), .WRAP_MODE(1), .LFSR_SEED(8'h01)) dut_w (
      .SC_RANDREG_BANK_CLOCK_50     (clk),
      .SC_RANDREG_BANK_RESET_InHigh (rst),
      .SC_RANDREG_BANK_clear_InLow  (clear_n),
      .SC_RANDREG_BANK_load_InLow   (load_n),
      .SC_RANDREG_BANK_mode_In      (mode),
      .SC_RANDREG_BANK_data_InBUS   (data),
      .SC_RANDREG_BANK_rdaddr_InBUS (rdaddr),
      .SC_RANDREG_BANK_data_OutBUS  (w_dout),
      .SC_RANDREG_BANK_count_OutBUS (w_count),
      .SC_RANDREG_BANK_full_Out     (w_full),
      .SC_RANDREG_BANK_overflow_Out (w_ovf),
      .SC_RANDREG_BANK_ack_Out      (w_ack)
   );

   // Reference LFSR: x^8 + x^6 + x^5 + x^4 + 1, shift left, feedback into bit 0
   always @(posedge clk) begin
      if (rst) model_lfsr <= 8'h01;
      else     model_lfsr <= {model_lfsr[6:0], model_lfsr[7] ^ model_lfsr[5] ^ model_lfsr[4] ^ model_lfsr[3]};
   end

   typedef struct {
      logic       clear_n;
      logic       load_n;
      logic [7:0] data;
      int         hold;
      int         acks;
      int         cnt;
      logic       full;
      logic       ovf;
      int         w_acks;
      int         w_cnt;
      logic       w_ovf;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
   endtask

   // Entered at a negedge; returns at a negedge with buttons released and the FSM back in IDLE
   task automatic run_action(input logic c_n, input logic l_n, input logic [7:0] d, input int hold,
                             output int acks, output int w_acks);
      acks = 0;
      w_acks = 0;
      clear_n = c_n;
      load_n = l_n;
      data = d;
      repeat (hold) begin
         @(negedge clk);
         acks += int'(ack);
         w_acks += int'(w_ack);
      end
      clear_n = 1'b1;
      load_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         acks += int'(ack);
         w_acks += int'(w_ack);
      end
   endtask

   task automatic read_both(input logic [1:0] addr, output logic [7:0] d, output logic [7:0] wd);
      rdaddr = addr;
      @(negedge clk);
      d = dout;
      wd = w_dout;
   endtask

   initial begin
      int acks, w_acks, period, lfsr_mism;
      logic zero_seen;
      logic [7:0] rd, wrd, exp_lfsr, v0;
      logic [7:0] exp_regs [4];
      logic [7:0] exp_wregs [4];

      vecs[0] = '{1'b0, 1'b1, 8'h00, 3, 1, 0, 1'b0, 1'b0, 1, 0, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 8'h11, 2, 1, 1, 1'b0, 1'b0, 1, 1, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 8'h22, 2, 1, 2, 1'b0, 1'b0, 1, 2, 1'b0};
      vecs[3] = '{1'b1, 1'b0, 8'h33, 2, 1, 3, 1'b0, 1'b0, 1, 3, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 8'h44, 2, 1, 4, 1'b1, 1'b0, 1, 4, 1'b0};
      vecs[5] = '{1'b1, 1'b0, 8'h55, 2, 0, 4, 1'b1, 1'b1, 1, 4, 1'b0};
      vecs[6] = '{1'b0, 1'b0, 8'h77, 2, 1, 0, 1'b0, 1'b0, 1, 0, 1'b0};
      exp_regs  = '{8'h11, 8'h22, 8'h33, 8'h44};
      exp_wregs = '{8'h55, 8'h22, 8'h33, 8'h44};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_dout", int'(dout), 0);
      check("rst_count", int'(count), 0);
      check("rst_full", int'(full), 0);
      check("rst_ovf", int'(ovf), 0);
      check("rst_ack", int'(ack), 0);
      check("rst_lfsr", int'(dut.u_lfsr.lfsr_q), 8'h01);
      check("rst_state", int'(dut.state_q), int'(IDLE));
      rst = 1'b0;
      @(negedge clk);

      // Single held load: one ack, two-cycle read latency from the LOAD state
      rdaddr = 2'd0;
      mode = 1'b0;
      data = 8'hA5;
      load_n = 1'b0;
      acks = 0;
      @(negedge clk);
      check("lat_state_load", int'(dut.state_q), int'(LOAD));
      check("lat_c1_dout", int'(dout), 0);
      @(negedge clk);
      acks += int'(ack);
      check("lat_c2_ack", int'(ack), 1);
      check("lat_c2_dout", int'(dout), 0);
      @(negedge clk);
      acks += int'(ack);
      check("lat_c3_dout", int'(dout), 8'hA5);
      check("lat_c3_ack", int'(ack), 0);
      repeat (2) begin
         @(negedge clk);
         acks += int'(ack);
      end
      load_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         acks += int'(ack);
      end
      check("held_load_acks", acks, 1);
      check("held_load_count", int'(count), 1);

      // Table: clear, five loads (refuse vs wrap), then clear+load together
      for (int i = 0; i < 7; i++) begin
         run_action(vecs[i].clear_n, vecs[i].load_n, vecs[i].data, vecs[i].hold, acks, w_acks);
         check($sformatf("v%0d_acks", i), acks, vecs[i].acks);
         check($sformatf("v%0d_count", i), int'(count), vecs[i].cnt);
         check($sformatf("v%0d_full", i), int'(full), int'(vecs[i].full));
         check($sformatf("v%0d_ovf", i), int'(ovf), int'(vecs[i].ovf));
         check($sformatf("v%0d_w_acks", i), w_acks, vecs[i].w_acks);
         check($sformatf("v%0d_w_count", i), int'(w_count), vecs[i].w_cnt);
         check($sformatf("v%0d_w_full", i), int'(w_full), int'(vecs[i].full));
         check($sformatf("v%0d_w_ovf", i), int'(w_ovf), int'(vecs[i].w_ovf));
         if (i == 5) begin
            for (int a = 0; a < 4; a++) begin
               read_both(2'(a), rd, wrd);
               check($sformatf("reg%0d", a), int'(rd), int'(exp_regs[a]));
               check($sformatf("w_reg%0d", a), int'(wrd), int'(exp_wregs[a]));
            end
         end
      end
      read_both(2'd0, rd, wrd);
      check("clr_ld_reg0", int'(rd), 0);
      check("clr_ld_w_reg0", int'(wrd), 0);

      // LFSR-sourced load: the value held during the LOAD cycle is written
      mode = 1'b1;
      load_n = 1'b0;
      @(negedge clk);
      exp_lfsr = model_lfsr;
      @(negedge clk);
      load_n = 1'b1;
      repeat (4) @(negedge clk);
      mode = 1'b0;
      read_both(2'd0, rd, wrd);
      check("lfsr_load_reg0", int'(rd), int'(exp_lfsr));
      check("lfsr_load_w_reg0", int'(wrd), int'(exp_lfsr));
      check("lfsr_load_count", int'(count), 1);

      // LFSR sequence, period and zero-freedom
      v0 = dut.u_lfsr.lfsr_q;
      period = 0;
      zero_seen = 1'b0;
      lfsr_mism = 0;
      for (int c = 1; c <= 600; c++) begin
         @(negedge clk);
         if (dut.u_lfsr.lfsr_q != model_lfsr) lfsr_mism++;
         if (dut.u_lfsr.lfsr_q == 8'h00) zero_seen = 1'b1;
         if (period == 0 && dut.u_lfsr.lfsr_q == v0) period = c;
      end
      check("lfsr_vs_model_mismatches", lfsr_mism, 0);
      check("lfsr_period", period, 255);
      check("lfsr_zero_seen", int'(zero_seen), 0);

      // Reset during LOAD aborts the write; a button held through reset is a new request
      run_action(1'b0, 1'b1, 8'h00, 2, acks, w_acks);
      rdaddr = 2'd0;
      data = 8'h3C;
      load_n = 1'b0;
      @(negedge clk);
      check("abort_state_load", int'(dut.state_q), int'(LOAD));
      rst = 1'b1;
      @(negedge clk);
      check("abort_count", int'(count), 0);
      check("abort_ack", int'(ack), 0);
      check("abort_state", int'(dut.state_q), int'(IDLE));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("abort_reg0", int'(dout), 0);
      check("post_rst_state", int'(dut.state_q), int'(LOAD));
      @(negedge clk);
      check("post_rst_ack", int'(ack), 1);
      load_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_count", int'(count), 1);
      read_both(2'd0, rd, wrd);
      check("post_rst_reg0", int'(rd), 8'h3C);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sc_randreg_bank.md
SC_RANDREG_BANK -- requirements
Module: sc_randreg_bank

Interface
REQ-001 The block SHALL have parameter DATAWIDTH_BUS, default 8, register/LFSR width, legal range 4..16.
REQ-002 The block SHALL have parameter DEPTH, default 4, number of registers, power of two, 2..16.
REQ-003 The block SHALL have parameter WRAP_MODE, default 0: 0 = refuse loads when full; 1 = wrap and overwrite the oldest entry.
REQ-004 The block SHALL have parameter LFSR_SEED, default 1, nonzero LFSR reset value.
REQ-005 The block SHALL have port SC_RANDREG_BANK_CLOCK_50  in  1  the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port SC_RANDREG_BANK_RESET_InHigh  in  1  synchronous, active-high reset.
REQ-007 The block SHALL have port SC_RANDREG_BANK_clear_InLow  in  1  debounced clear request, active low.
REQ-008 The block SHALL have port SC_RANDREG_BANK_load_InLow  in  1  debounced load request, active low.
REQ-009 The block SHALL have port SC_RANDREG_BANK_mode_In  in  1  source select: 0 = data_InBUS, 1 = internal LFSR.
REQ-010 The block SHALL have port SC_RANDREG_BANK_data_InBUS  in  DATAWIDTH_BUS  external load data.
REQ-011 The block SHALL have port SC_RANDREG_BANK_rdaddr_InBUS  in  clog2(DEPTH)  read address.
REQ-012 The block SHALL have port SC_RANDREG_BANK_data_OutBUS  out  DATAWIDTH_BUS  registered contents of reg[rdaddr].
REQ-013 The block SHALL have port SC_RANDREG_BANK_count_OutBUS  out  clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
REQ-014 The block SHALL have port SC_RANDREG_BANK_full_Out  out  1  high when count == DEPTH.
REQ-015 The block SHALL have port SC_RANDREG_BANK_overflow_Out  out  1  sticky flag: a load was refused (WRAP_MODE=0 only).
REQ-016 The block SHALL have port SC_RANDREG_BANK_ack_Out  out  1  one-cycle pulse on every completed write or clear.

Function
REQ-017 The LFSR SHALL be a maximal-length Fibonacci LFSR of DATAWIDTH_BUS bits that advances every cycle, independent of the FSM.
REQ-018 If the LFSR ever holds all zeros, it SHALL reload LFSR_SEED on the next edge.
REQ-019 The FSM SHALL have states IDLE, LOAD, CLEAR and WAIT_REL.
REQ-020 In IDLE with clear_InLow==0, the next state SHALL be CLEAR; clear has priority over a simultaneous load.
REQ-021 In IDLE with load_InLow==0 and clear high, the next state SHALL be LOAD if not full or WRAP_MODE=1.
REQ-022 Otherwise, for a load request, the next state SHALL be WAIT_REL and overflow SHALL be set.
REQ-023 In LOAD, the source value present that cycle SHALL be written to reg[wr_ptr] on the next edge; wr_ptr increments modulo DEPTH.
REQ-024 On that same LOAD edge, count SHALL increment, saturating at DEPTH in WRAP_MODE=1.
REQ-025 In LOAD, ack SHALL be asserted and the FSM SHALL go to WAIT_REL.
REQ-026 In CLEAR, all registers SHALL be zeroed, wr_ptr and count SHALL become 0, overflow SHALL be cleared, ack SHALL be asserted, and the next state SHALL be WAIT_REL.
REQ-027 WAIT_REL SHALL return to IDLE only when both clear_InLow and load_InLow are high, so a held button yields exactly one action.
REQ-028 data_OutBUS SHALL equal reg[rdaddr] sampled one cycle earlier: 1-cycle read latency, and a write becomes visible 1 cycle after the write edge.
REQ-029 full_Out SHALL be combinational from count; ack_Out SHALL be registered, high for exactly one cycle per action.

Reset
REQ-030 While RESET_InHigh is sampled high, the block SHALL load: state IDLE, all registers 0, wr_ptr 0, count 0, overflow 0, ack 0, data_OutBUS 0, LFSR = LFSR_SEED.
REQ-031 A reset asserted mid-LOAD or mid-CLEAR SHALL abort the action; no partial write SHALL be retained.
REQ-032 After reset deassertion, a button still held low SHALL be treated as a new request.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the LFSR tap-mask constant table indexed by width (4..16), and a clog2 helper.
REQ-034 The LFSR SHALL be a separate sub-module, sc_randreg_lfsr, parametrised by width and seed; the FSM, register array and pointers SHALL reside in the top module.

Verification
REQ-035 Scenario: reset, then mode=0, data=8'hA5, a 5-cycle load pulse -> exactly one ack; reg[0]=A5; count=1; rdaddr=0 gives data_OutBUS=A5 two cycles after the LOAD state.
REQ-036 Scenario: with DEPTH=4 and WRAP_MODE=0, five separate loads of 11,22,33,44,55 -> full=1, count=4, overflow=1, regs hold 11..44.
REQ-037 Scenario: with WRAP_MODE=1, the same five loads -> reg[0]=55, count=4, overflow=0.
REQ-038 Scenario: clear and load asserted low in the same cycle -> a CLEAR action only; count=0; no write.
REQ-039 Scenario: mode=1, load at a known cycle -> the written value equals the reference-model LFSR value for that cycle; the LFSR is never zero over 2^W cycles and has period 2^W-1.
REQ-040 Scenario: reset asserted during the LOAD cycle -> the register stays 0, count=0, state IDLE.
